ita_serdiv_array: RTL and testbench
===================================

// Module: ita_serdiv_array
// PURPOSE
//  Multi-unit iterative integer divider for ITA post-processing (softmax normalisation, requant scales).
//  NUM_UNITS radix-2 restoring dividers run concurrently so one op can be issued per cycle while a unit is free.
//  Results retire strictly in issue order with a user tag, so the block drops into an in-order stream pipeline.
// PARAMETERS
//  WIDTH      32  operand/result width in bits (>=4)
//  NUM_UNITS  4   number of parallel divider units (>=1, power of two)
//  TAG_W      4   width of the tag carried alongside each operation
// PORTS
//  clk_i      in   1         clock, all state updates on rising edge
//  rst_i      in   1         synchronous reset, active high
//  flush_i    in   1         synchronous abort of all in-flight operations
//  in_vld_i   in   1         operation valid
//  in_rdy_o   out  1         block can accept an operation this cycle
//  op_a_i     in   WIDTH     dividend
//  op_b_i     in   WIDTH     divisor
//  opcode_i   in   2         0 udiv, 1 div, 2 urem, 3 rem (bit0 signed, bit1 remainder)
//  tag_i      in   TAG_W     user tag, returned unchanged with result
//  out_vld_o  out  1         result valid
//  out_rdy_i  in   1         downstream accepts result
//  res_o      out  WIDTH     quotient or remainder per opcode
//  tag_o      out  TAG_W     tag of the operation in res_o
// BEHAVIOUR
//  Reset (rst_i=1 at edge): all units IDLE, dispatch and retire pointers 0; out_vld_o=0, in_rdy_o=1 next cycle,
//   res_o/tag_o=0. Reset dominates flush_i and any handshake in the same cycle.
//  Unit FSM: IDLE -> (accepted) -> BUSY -> DONE -> (retired) -> IDLE. Unit holds operands, count, q, r, flags, tag.
//  Dispatch: in_rdy_o = (unit[disp_ptr] is IDLE) & ~flush_i. Accept on in_vld_i & in_rdy_o; disp_ptr increments mod
//   NUM_UNITS. in_rdy_o does not depend combinationally on in_vld_i.
//  Retire: out_vld_o = (unit[ret_ptr] is DONE) & ~flush_i; res_o/tag_o driven from that unit's registers.
//   On out_vld_o & out_rdy_i unit returns to IDLE, ret_ptr increments. Outputs stable while out_vld_o & ~out_rdy_i.
//  Same-cycle retire of unit k and dispatch to unit k: not allowed (unit k IDLE only from the following cycle).
//  Arithmetic: signed ops use magnitudes |a|,|b| (unsigned WIDTH bits; |MIN| = 2^(WIDTH-1) fits) and unsigned
//   restoring division, one quotient bit per cycle, MSB first; 2*r+bit compared in WIDTH+1 bits.
//   Sign fix on DONE entry: quotient negated iff a,b signs differ; remainder takes dividend sign. Wraps mod 2^WIDTH.
//  Latency (accept edge = cycle 0): normal ops DONE at cycle WIDTH+1, out_vld_o high that cycle.
//   Early exit, DONE at cycle 1: b==0 -> q=all ones, r=a (signed and unsigned);
//   |b|>|a| -> q=0, r=a; a==0 -> q=0, r=0.
//  Overflow: signed MIN / -1 -> q=MIN, r=0 (falls out of the datapath, no special case needed).
//  Ordering: early-exit op issued after a long op waits in DONE until all earlier ops retire.
//  Full: when all NUM_UNITS busy/done, in_rdy_o=0 until unit[disp_ptr] retires. Pointers wrap mod NUM_UNITS.
//  flush_i: combinationally forces in_rdy_o=0, out_vld_o=0; at the edge all units IDLE, both pointers 0,
//   no handshake recorded that cycle. Block accepts again the cycle after flush_i deasserts.
// TESTING (WIDTH=8, NUM_UNITS=2, TAG_W=4 unless noted)
//  div a=0xF9(-7) b=0x02 tag=3 -> res_o=0xFD(-3) tag_o=3 at cycle 9; rem same operands -> 0xFF(-1)
//  udiv a=0x25 b=0x00 -> 0xFF at cycle 1; urem same -> 0x25; div a=0x80 b=0xFF -> 0x80, rem -> 0x00
//  udiv 200/3 tag=0, then next cycle udiv 1/5 tag=1 -> first out 0x42 tag 0 at cycle 9, then 0x00 tag 1 cycle 10
//  Back-to-back 3 ops, out_rdy_i=0 -> in_rdy_o=0 after 2 accepts; release out_rdy_i -> in order, none lost/duplicated
//  flush_i with 2 ops in flight -> out_vld_o=0 same cycle, in_rdy_o=1 after deassert, next op tag 5 retires first
//  Random 10k ops, WIDTH=32, NUM_UNITS=4, random stalls vs reference model; reset mid-stream -> all state cleared

Source files
------------

// File: rtl/ita_serdiv_array.sv
// Array of radix-2 restoring dividers with in-order, tagged retirement.
// Units are filled round-robin by a dispatch pointer and drained by a retire pointer.
module ita_serdiv_array #(
  parameter int WIDTH     = 32,
  parameter int NUM_UNITS = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [1:0]       opcode_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] res_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } unit_st_e;

  unit_st_e         st_q   [NUM_UNITS];
  unit_st_e         st_d   [NUM_UNITS];
  logic             first_q[NUM_UNITS];
  logic             first_d[NUM_UNITS];
  logic [CNT_W-1:0] cnt_q  [NUM_UNITS];
  logic [CNT_W-1:0] cnt_d  [NUM_UNITS];
  logic [WIDTH-1:0] a_q    [NUM_UNITS];
  logic [WIDTH-1:0] a_d    [NUM_UNITS];
  logic [WIDTH-1:0] dq_q   [NUM_UNITS];
  logic [WIDTH-1:0] dq_d   [NUM_UNITS];
  logic [WIDTH-1:0] dvs_q  [NUM_UNITS];
  logic [WIDTH-1:0] dvs_d  [NUM_UNITS];
  logic [WIDTH-1:0] rem_q  [NUM_UNITS];
  logic [WIDTH-1:0] rem_d  [NUM_UNITS];
  logic [WIDTH-1:0] res_q  [NUM_UNITS];
  logic [WIDTH-1:0] res_d  [NUM_UNITS];
  logic [TAG_W-1:0] tag_q  [NUM_UNITS];
  logic [TAG_W-1:0] tag_d  [NUM_UNITS];
  logic             qneg_q [NUM_UNITS];
  logic             qneg_d [NUM_UNITS];
  logic             rneg_q [NUM_UNITS];
  logic             rneg_d [NUM_UNITS];
  logic             rsel_q [NUM_UNITS];
  logic             rsel_d [NUM_UNITS];
  logic [PTR_W-1:0] disp_ptr_q, disp_ptr_d;
  logic [PTR_W-1:0] ret_ptr_q, ret_ptr_d;
  logic             accept_s, retire_s;

  function automatic logic [WIDTH-1:0] negate_f(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1'b1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? negate_f(v) : v;
  endfunction

  // One restoring step: returns {next remainder, dividend/quotient shift register}.
  function automatic logic [2*WIDTH-1:0] step_f(input logic [WIDTH-1:0] rem,
                                                input logic [WIDTH-1:0] dq,
                                                input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] trial;
    trial = {rem, dq[WIDTH-1]};
    if (trial >= {1'b0, dvs}) begin
      trial = trial - {1'b0, dvs};
      return {trial[WIDTH-1:0], dq[WIDTH-2:0], 1'b1};
    end else begin
      return {trial[WIDTH-1:0], dq[WIDTH-2:0], 1'b0};
    end
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc_f(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_UNITS - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1'b1);
  endfunction

  // Handshakes, pointer advance and per-unit next state / datapath.
  always_comb begin
    in_rdy_o   = (st_q[disp_ptr_q] == ST_IDLE) && !flush_i;
    out_vld_o  = (st_q[ret_ptr_q] == ST_DONE) && !flush_i;
    res_o      = res_q[ret_ptr_q];
    tag_o      = tag_q[ret_ptr_q];
    accept_s   = in_vld_i && in_rdy_o;
    retire_s   = out_vld_o && out_rdy_i;
    disp_ptr_d = accept_s ? ptr_inc_f(disp_ptr_q) : disp_ptr_q;
    ret_ptr_d  = retire_s ? ptr_inc_f(ret_ptr_q) : ret_ptr_q;
    for (int u = 0; u < NUM_UNITS; u++) begin
      st_d[u]    = st_q[u];
      first_d[u] = first_q[u];
      cnt_d[u]   = cnt_q[u];
      a_d[u]     = a_q[u];
      dq_d[u]    = dq_q[u];
      dvs_d[u]   = dvs_q[u];
      rem_d[u]   = rem_q[u];
      res_d[u]   = res_q[u];
      tag_d[u]   = tag_q[u];
      qneg_d[u]  = qneg_q[u];
      rneg_d[u]  = rneg_q[u];
      rsel_d[u]  = rsel_q[u];
      case (st_q[u])
        ST_IDLE: begin
          if (accept_s && (disp_ptr_q == PTR_W'(u))) begin
            st_d[u]    = ST_BUSY;
            first_d[u] = 1'b1;
            cnt_d[u]   = {CNT_W{1'b0}};
            a_d[u]     = op_a_i;
            dq_d[u]    = abs_f(op_a_i, opcode_i[0]);
            dvs_d[u]   = abs_f(op_b_i, opcode_i[0]);
            qneg_d[u]  = opcode_i[0] & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
            rneg_d[u]  = opcode_i[0] & op_a_i[WIDTH-1];
            rsel_d[u]  = opcode_i[1];
            tag_d[u]   = tag_i;
          end else begin
            st_d[u] = ST_IDLE;
          end
        end
        ST_BUSY: begin
          // First busy cycle resolves the early exits; a==0 is covered by |b|>|a|.
          if (first_q[u]) begin
            if (dvs_q[u] == {WIDTH{1'b0}}) begin
              st_d[u]  = ST_DONE;
              res_d[u] = rsel_q[u] ? a_q[u] : {WIDTH{1'b1}};
            end else if (dvs_q[u] > dq_q[u]) begin
              st_d[u]  = ST_DONE;
              res_d[u] = rsel_q[u] ? a_q[u] : {WIDTH{1'b0}};
            end else begin
              first_d[u] = 1'b0;
              rem_d[u]   = {WIDTH{1'b0}};
            end
          end else begin
            {rem_d[u], dq_d[u]} = step_f(rem_q[u], dq_q[u], dvs_q[u]);
            cnt_d[u] = cnt_q[u] + CNT_W'(1'b1);
            if (cnt_q[u] == CNT_W'(WIDTH - 1)) begin
              st_d[u]  = ST_DONE;
              res_d[u] = rsel_q[u] ? (rneg_q[u] ? negate_f(rem_d[u]) : rem_d[u])
                                   : (qneg_q[u] ? negate_f(dq_d[u]) : dq_d[u]);
            end else begin
              st_d[u] = ST_BUSY;
            end
          end
        end
        ST_DONE: begin
          if (retire_s && (ret_ptr_q == PTR_W'(u))) begin
            st_d[u] = ST_IDLE;
          end else begin
            st_d[u] = ST_DONE;
          end
        end
        default: st_d[u] = ST_IDLE;
      endcase
    end
  end

  // Control state: reset and flush both clear unit states and pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      disp_ptr_q <= {PTR_W{1'b0}};
      ret_ptr_q  <= {PTR_W{1'b0}};
      for (int u = 0; u < NUM_UNITS; u++) begin
        st_q[u] <= ST_IDLE;
      end
    end else begin
      disp_ptr_q <= disp_ptr_d;
      ret_ptr_q  <= ret_ptr_d;
      for (int u = 0; u < NUM_UNITS; u++) begin
        st_q[u] <= st_d[u];
      end
    end
  end

  // Per-unit operand, iteration and result registers.
  always_ff @(posedge clk_i) begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (rst_i) begin
        first_q[u] <= 1'b0;
        cnt_q[u]   <= {CNT_W{1'b0}};
        a_q[u]     <= {WIDTH{1'b0}};
        dq_q[u]    <= {WIDTH{1'b0}};
        dvs_q[u]   <= {WIDTH{1'b0}};
        rem_q[u]   <= {WIDTH{1'b0}};
        res_q[u]   <= {WIDTH{1'b0}};
        tag_q[u]   <= {TAG_W{1'b0}};
        qneg_q[u]  <= 1'b0;
        rneg_q[u]  <= 1'b0;
        rsel_q[u]  <= 1'b0;
      end else begin
        first_q[u] <= first_d[u];
        cnt_q[u]   <= cnt_d[u];
        a_q[u]     <= a_d[u];
        dq_q[u]    <= dq_d[u];
        dvs_q[u]   <= dvs_d[u];
        rem_q[u]   <= rem_d[u];
        res_q[u]   <= res_d[u];
        tag_q[u]   <= tag_d[u];
        qneg_q[u]  <= qneg_d[u];
        rneg_q[u]  <= rneg_d[u];
        rsel_q[u]  <= rsel_d[u];
      end
    end
  end

endmodule

// File: tb/tb_ita_serdiv_array.sv
// Bench for ita_serdiv_array: directed 8-bit/2-unit cases, then randomized 32-bit/4-unit traffic
// scored against an arithmetic reference model with an in-order expectation queue.
module tb_ita_serdiv_array;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, flush8, in_vld8, in_rdy8, out_vld8, out_rdy8;
  logic [7:0] a8, b8, res8;
  logic [1:0] opc8;
  logic [3:0] tag8, tago8;

  logic        rst32, flush32, in_vld32, in_rdy32, out_vld32, out_rdy32;
  logic [31:0] a32, b32, res32;
  logic [1:0]  opc32;
  logic [3:0]  tag32, tago32;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];

  ita_serdiv_array #(.WIDTH(8), .NUM_UNITS(2), .TAG_W(4)) dut8 (
    .clk_i(clk), .rst_i(rst8), .flush_i(flush8), .in_vld_i(in_vld8), .in_rdy_o(in_rdy8),
    .op_a_i(a8), .op_b_i(b8), .opcode_i(opc8), .tag_i(tag8),
    .out_vld_o(out_vld8), .out_rdy_i(out_rdy8), .res_o(res8), .tag_o(tago8)
  );

  ita_serdiv_array #(.WIDTH(32), .NUM_UNITS(4), .TAG_W(4)) dut32 (
    .clk_i(clk), .rst_i(rst32), .flush_i(flush32), .in_vld_i(in_vld32), .in_rdy_o(in_rdy32),
    .op_a_i(a32), .op_b_i(b32), .opcode_i(opc32), .tag_i(tag32),
    .out_vld_o(out_vld32), .out_rdy_i(out_rdy32), .res_o(res32), .tag_o(tago32)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: plain integer division with the block's divide-by-zero convention.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 255));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op on the 8-bit instance and measure latency from the accept edge.
  task automatic run8(input string name, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [3:0] tag, input logic [7:0] exp_res,
                      input int exp_lat);
    int n;
    @(negedge clk);
    chk({name, "_rdy"}, in_rdy8, 1);
    in_vld8 = 1'b1; opc8 = op; a8 = a; b8 = b; tag8 = tag;
    @(negedge clk);
    in_vld8 = 1'b0;
    n = 0;
    while (!out_vld8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"}, n, exp_lat);
    chk({name, "_res"}, res8, exp_res);
    chk({name, "_tag"}, tago8, tag);
    @(negedge clk);
    chk({name, "_retired"}, out_vld8, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [35:0] e;
    logic [35:0] held;
    logic stalled;
    rst8 = 1'b1; flush8 = 1'b0; in_vld8 = 1'b0; out_rdy8 = 1'b1;
    a8 = 8'd0; b8 = 8'd0; opc8 = 2'd0; tag8 = 4'd0;
    rst32 = 1'b1; flush32 = 1'b0; in_vld32 = 1'b0; out_rdy32 = 1'b1;
    a32 = 32'd0; b32 = 32'd0; opc32 = 2'd0; tag32 = 4'd0;
    repeat (2) @(negedge clk);
    rst8 = 1'b0; rst32 = 1'b0;
    #1;
    chk("rst8_vld", out_vld8, 0);
    chk("rst8_rdy", in_rdy8, 1);
    chk("rst8_res", {tago8, res8}, 0);
    chk("rst32_vld", out_vld32, 0);
    chk("rst32_rdy", in_rdy32, 1);

    // Directed arithmetic and latency cases (WIDTH=8).
    run8("div_neg",   2'd1, 8'hF9, 8'h02, 4'd3,  8'hFD, 9);
    run8("rem_neg",   2'd3, 8'hF9, 8'h02, 4'd3,  8'hFF, 9);
    run8("udiv_by0",  2'd0, 8'h25, 8'h00, 4'd1,  8'hFF, 1);
    run8("urem_by0",  2'd2, 8'h25, 8'h00, 4'd2,  8'h25, 1);
    run8("div_ovf",   2'd1, 8'h80, 8'hFF, 4'd4,  8'h80, 9);
    run8("rem_ovf",   2'd3, 8'h80, 8'hFF, 4'd4,  8'h00, 9);
    run8("div_a0",    2'd1, 8'h00, 8'h07, 4'd9,  8'h00, 1);
    run8("rem_small", 2'd3, 8'hFB, 8'h09, 4'd10, 8'hFB, 1);
    run8("sdiv_by0",  2'd1, 8'h85, 8'h00, 4'd11, 8'hFF, 1);

    // Early-exit op behind a long op must wait its turn.
    @(negedge clk);
    chk("pipe_rdy1", in_rdy8, 1);
    in_vld8 = 1'b1; opc8 = 2'd0; a8 = 8'd200; b8 = 8'd3; tag8 = 4'd0;
    @(negedge clk);
    chk("pipe_rdy2", in_rdy8, 1);
    a8 = 8'd1; b8 = 8'd5; tag8 = 4'd1;
    @(negedge clk);
    in_vld8 = 1'b0;
    n = 1;
    while (!out_vld8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("pipe_lat", n, 9);
    chk("pipe_first", {tago8, res8}, {4'd0, 8'h42});
    @(negedge clk);
    chk("pipe_vld2", out_vld8, 1);
    chk("pipe_second", {tago8, res8}, {4'd1, 8'h00});
    @(negedge clk);
    chk("pipe_empty", out_vld8, 0);

    // Flush with two ops in flight.
    out_rdy8 = 1'b0;
    @(negedge clk);
    in_vld8 = 1'b1; opc8 = 2'd0; a8 = 8'd90; b8 = 8'd9; tag8 = 4'd1;
    @(negedge clk);
    a8 = 8'd91; b8 = 8'd7; tag8 = 4'd2;
    @(negedge clk);
    in_vld8 = 1'b0;
    n = 0;
    while (!out_vld8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("flush_pre_vld", out_vld8, 1);
    flush8 = 1'b1;
    #1;
    chk("flush_vld", out_vld8, 0);
    chk("flush_rdy", in_rdy8, 0);
    @(negedge clk);
    flush8 = 1'b0;
    #1;
    chk("flush_rdy_after", in_rdy8, 1);
    chk("flush_vld_after", out_vld8, 0);
    out_rdy8 = 1'b1;
    run8("post_flush", 2'd0, 8'd9, 8'd3, 4'd5, 8'd3, 9);

    // Backpressure: two units fill, third op waits, all retire in order.
    out_rdy8 = 1'b0;
    @(negedge clk);
    in_vld8 = 1'b1; opc8 = 2'd0; a8 = 8'd100; b8 = 8'd7; tag8 = 4'd6;
    @(negedge clk);
    chk("bp_rdy2", in_rdy8, 1);
    a8 = 8'd50; b8 = 8'd5; tag8 = 4'd7;
    @(negedge clk);
    chk("bp_full", in_rdy8, 0);
    a8 = 8'd77; b8 = 8'd11; tag8 = 4'd8;
    repeat (12) @(negedge clk);
    chk("bp_still_full", in_rdy8, 0);
    chk("bp_vld", out_vld8, 1);
    chk("bp_first", {tago8, res8}, {4'd6, 8'h0E});
    out_rdy8 = 1'b1;
    @(negedge clk);
    chk("bp_second", {tago8, res8}, {4'd7, 8'h0A});
    chk("bp_rdy_free", in_rdy8, 1);
    @(negedge clk);
    in_vld8 = 1'b0;
    n = 0;
    while (!out_vld8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_third", {tago8, res8}, {4'd8, 8'h07});
    @(negedge clk);
    chk("bp_empty", out_vld8, 0);

    // Randomized traffic (WIDTH=32, 4 units) with a reset between the two phases.
    stalled = 1'b0;
    held = 36'd0;
    for (int phase = 0; phase < 2; phase++) begin
      for (int cyc = 0; cyc < 15000; cyc++) begin
        @(negedge clk);
        if (stalled) begin
          chk("stall_vld", out_vld32, 1);
          chk("stall_hold", {tago32, res32}, held);
        end
        in_vld32  = ($urandom_range(0, 3) != 0);
        a32       = rnd_opnd();
        b32       = rnd_opnd();
        opc32     = 2'($urandom_range(0, 3));
        tag32     = 4'($urandom_range(0, 15));
        out_rdy32 = ($urandom_range(0, 3) != 0);
        if (out_vld32 && out_rdy32) begin
          chk("rnd_pending", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rnd_res", res32, e[31:0]);
            chk("rnd_tag", tago32, e[35:32]);
          end
        end
        if (in_vld32 && in_rdy32) exp_q.push_back({tag32, ref_div(opc32, a32, b32)});
        stalled = out_vld32 && !out_rdy32;
        held = {tago32, res32};
      end
      if (phase == 0) begin
        @(negedge clk);
        rst32 = 1'b1;
        in_vld32 = 1'b1;
        out_rdy32 = 1'b1;
        @(negedge clk);
        rst32 = 1'b0;
        in_vld32 = 1'b0;
        #1;
        chk("mid_rst_vld", out_vld32, 0);
        chk("mid_rst_rdy", in_rdy32, 1);
        chk("mid_rst_out", {tago32, res32}, 0);
        exp_q.delete();
        stalled = 1'b0;
      end
    end

    // Drain whatever is still in flight.
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk);
      in_vld32 = 1'b0;
      out_rdy32 = 1'b1;
      if (out_vld32) begin
        e = exp_q.pop_front();
        chk("drain_res", res32, e[31:0]);
        chk("drain_tag", tago32, e[35:32]);
      end
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("drain_no_extra", out_vld32, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
